// File: rtl/gray_counter_pkg.sv
// Gray-code helpers shared by the counter and anything that consumes its
// outputs (FIFO pointer compare, CDC synchronisers).
// The functions operate on a fixed maximum width; the GRAY_BIN2GRAY and
// GRAY_GRAY2BIN macro wrappers zero-extend an operand of any width W up to
// that maximum and truncate the result back to W. Zero extension is harmless
// for both conversions because the extra upper bits are all zero.
package gray_pkg;

    localparam int GRAY_MAX_W = 64;

    // Binary to Gray: each bit is the XOR of itself and its upper neighbour.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: prefix XOR running down from the MSB.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

`ifndef GRAY_PKG_MACROS
`define GRAY_PKG_MACROS
`define GRAY_BIN2GRAY(w, x) (w'(gray_pkg::bin2gray(gray_pkg::GRAY_MAX_W'(x))))
`define GRAY_GRAY2BIN(w, x) (w'(gray_pkg::gray2bin(gray_pkg::GRAY_MAX_W'(x))))
`endif

// File: rtl/gray_counter_if.sv
// Control and result bundle of the Gray counter. The master side drives the
// clear/load/count controls; the slave side (the counter) returns the
// registered binary count, its Gray form and the wrap pulse.
interface gray_counter_if #(
    parameter int W = 4
);
    logic         clr;
    logic         ld;
    logic [W-1:0] ld_val;
    logic         en;
    logic         dn;
    logic [W-1:0] bin_r;
    logic [W-1:0] gray_r;
    logic         wrap_r;

    modport master (
        output clr, ld, ld_val, en, dn,
        input  bin_r, gray_r, wrap_r
    );

    modport slave (
        input  clr, ld, ld_val, en, dn,
        output bin_r, gray_r, wrap_r
    );
endinterface

// File: rtl/gray_counter.sv
// Up/down binary counter with a registered Gray-code copy, for async-FIFO
// pointers and other counters that cross clock domains. The Gray value is
// computed from the next binary value and registered, so the output comes
// straight from flops and moves by exactly one bit per count step.
// Control priority: clr > ld > en; with none asserted the count holds.
// Build option: define GRAY_COUNTER_SAT_EN to saturate at the ends instead of
// wrapping; wrap_r then flags each count request blocked by saturation.
module gray_counter
    import gray_pkg::*;
#(
    parameter int           W    = 4,
    parameter logic [W-1:0] INIT = '0
) (
    input  logic             clk,
    input  logic             rst,
    gray_counter_if.slave    bus
);

    localparam logic [W-1:0] ALL_ONES  = '1;
    localparam logic [W-1:0] ALL_ZEROS = '0;

    logic [W-1:0] r_bin;
    logic [W-1:0] r_gray;
    logic         r_wrap;

    logic [W-1:0] w_bin_nxt;
    logic [W-1:0] w_gray_nxt;
    logic         w_wrap_nxt;
    logic         w_at_edge;

    // Next binary value and boundary flag from the clr/ld/up/down mux.
    always_comb begin
        w_bin_nxt  = r_bin;
        w_wrap_nxt = 1'b0;
        w_at_edge  = bus.dn ? (r_bin == ALL_ZEROS) : (r_bin == ALL_ONES);
        if (bus.clr) begin
            w_bin_nxt = INIT;
        end else if (bus.ld) begin
            w_bin_nxt = bus.ld_val;
        end else if (bus.en) begin
            // Crossing the 2^W boundary raises wrap in both build variants;
            // only the resulting count differs.
            w_wrap_nxt = w_at_edge;
`ifdef GRAY_COUNTER_SAT_EN
            if (!w_at_edge) begin
                w_bin_nxt = bus.dn ? (r_bin - 1'b1) : (r_bin + 1'b1);
            end
`else
            w_bin_nxt = bus.dn ? (r_bin - 1'b1) : (r_bin + 1'b1);
`endif
        end
        w_gray_nxt = `GRAY_BIN2GRAY(W, w_bin_nxt);
    end

    // Binary, Gray and wrap registers share one async-reset process so they
    // always move together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin  <= INIT;
            r_gray <= `GRAY_BIN2GRAY(W, INIT);
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign bus.bin_r  = r_bin;
    assign bus.gray_r = r_gray;
    assign bus.wrap_r = r_wrap;

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    gray_counter_if #(.W(W)) bus ();

    gray_counter #(.W(W), .INIT('0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer arithmetic on the count value.
    int m_bin      = 0;
    int m_wrap     = 0;
    int m_prev_bin = 0;
    int m_en_only  = 0;
    int m_valid    = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bin     <= 0;
            m_wrap    <= 0;
            m_en_only <= 0;
            m_valid   <= 0;
        end else begin
            m_prev_bin <= m_bin;
            m_valid    <= 1;
            m_en_only  <= (!bus.clr && !bus.ld && bus.en) ? 1 : 0;
            if (bus.clr) begin
                m_bin  <= 0;
                m_wrap <= 0;
            end else if (bus.ld) begin
                m_bin  <= int'(bus.ld_val);
                m_wrap <= 0;
            end else if (bus.en) begin
                if (!bus.dn) begin
                    m_wrap <= (m_bin + 1 >= 16) ? 1 : 0;
`ifdef GRAY_COUNTER_SAT_EN
                    m_bin  <= (m_bin + 1 >= 16) ? m_bin : m_bin + 1;
`else
                    m_bin  <= (m_bin + 1) % 16;
`endif
                end else begin
                    m_wrap <= (m_bin - 1 < 0) ? 1 : 0;
`ifdef GRAY_COUNTER_SAT_EN
                    m_bin  <= (m_bin - 1 < 0) ? m_bin : m_bin - 1;
`else
                    m_bin  <= (m_bin + 15) % 16;
`endif
                end
            end else begin
                m_wrap <= 0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    logic [W-1:0] prev_gray;
    always @(negedge clk) begin
        int eg;
        eg = m_bin ^ (m_bin / 2);
        chk("bin_r", int'(bus.bin_r), m_bin);
        chk("gray_r", int'(bus.gray_r), eg);
        chk("wrap_r", int'(bus.wrap_r), m_wrap);
        if (m_valid != 0 && m_en_only != 0)
            chk("gray_step_bits", $countones(bus.gray_r ^ prev_gray),
                (m_bin != m_prev_bin) ? 1 : 0);
        prev_gray = bus.gray_r;
    end

    task automatic step(input logic c, input logic l, input int lv,
                        input logic e, input logic d);
        bus.clr    = c;
        bus.ld     = l;
        bus.ld_val = W'(lv);
        bus.en     = e;
        bus.dn     = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    int gseq [0:16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8, 0};

    initial begin
        bus.clr = 0; bus.ld = 0; bus.ld_val = '0; bus.en = 0; bus.dn = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_bin", int'(bus.bin_r), 0);
        chk("reset_gray", int'(bus.gray_r), 0);
        rst = 1'b0;

        // Count to 9, then assert reset asynchronously between edges.
        for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 0);
        chk("pre_reset_bin", int'(bus.bin_r), 9);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_bin", int'(bus.bin_r), 0);
        chk("async_rst_gray", int'(bus.gray_r), 0);
        chk("async_rst_wrap", int'(bus.wrap_r), 0);
        @(negedge clk);
        rst = 1'b0;

        // Full up-count cycle from 0, checked against the literal Gray sequence.
        for (int i = 1; i <= 16; i++) begin
            step(0, 0, 0, 1, 0);
            chk("up_gray_seq", int'(bus.gray_r), gseq[i]);
            chk("up_wrap_seq", int'(bus.wrap_r), (i == 16) ? 1 : 0);
        end

        // Load 5, then count down through zero.
        step(0, 1, 5, 0, 0);
        chk("ld5_bin", int'(bus.bin_r), 5);
        chk("ld5_gray", int'(bus.gray_r), 7);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 1);
            chk("dn_wrap_pulse", int'(bus.wrap_r), (i == 5) ? 1 : 0);
        end
        chk("dn_bin15", int'(bus.bin_r), 15);
        chk("dn_gray15", int'(bus.gray_r), 8);
        step(0, 0, 0, 0, 0);
        chk("idle_bin", int'(bus.bin_r), 15);
        chk("idle_wrap", int'(bus.wrap_r), 0);

        // Priority checks.
        step(1, 1, 7, 1, 0);
        chk("clr_wins_bin", int'(bus.bin_r), 0);
        chk("clr_wins_wrap", int'(bus.wrap_r), 0);
        step(0, 1, 7, 1, 0);
        chk("ld_over_en_bin", int'(bus.bin_r), 7);
        chk("ld_over_en_gray", int'(bus.gray_r), 4);

`ifdef GRAY_COUNTER_SAT_EN
        step(0, 1, 14, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 0);
            chk("sat_up_bin", int'(bus.bin_r), 15);
            chk("sat_up_wrap", int'(bus.wrap_r), (i == 0) ? 0 : 1);
        end
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("sat_dn_bin", int'(bus.bin_r), 0);
        chk("sat_dn_wrap", int'(bus.wrap_r), 1);
`endif

        // Random traffic; the per-cycle compare process does the checking.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
